// File: rtl/sdp_ram_arb2_pkg.sv
// -----------------------------------------------------------------------------
// sdp_ram_arb2_pkg
//   Shared definitions for the two-client simple-dual-port RAM arbiter:
//   the client index type, the client count and the round-robin pointer
//   reset value, plus a small index-to-one-hot helper.
// -----------------------------------------------------------------------------
package sdp_ram_arb2_pkg;

  localparam int N_CLIENTS = 2;

  // One bit selects client 0 or client 1.
  typedef logic client_t;

  // After reset client 0 is preferred on both ports.
  localparam client_t PTR_RST = 1'b0;

  function automatic logic [N_CLIENTS-1:0] oneHot(client_t idx);
    return N_CLIENTS'(1) << idx;
  endfunction

endpackage

// File: rtl/sdp_ram_arb2_if.sv
// -----------------------------------------------------------------------------
// sdp_ram_arb2_if
//   Bundle of every client-side and RAM-side signal of sdp_ram_arb2.
//   Modports:
//     slave  : the arbiter's view (takes requests and RAM read data, drives
//              acks, read returns and the RAM control/address/data lines)
//     master : the environment's view (clients plus the RAM itself)
//   Signals:
//     wrReq0/1, wrAdr0/1, wrDat0/1 : write requests, held until acked
//     wrAck0/1                     : write grant pulse (combinational)
//     rdReq0/1, rdAdr0/1           : read requests, held until acked
//     rdAck0/1                     : read grant pulse (combinational)
//     rdVld0/1, rdDat0/1           : read return, one cycle after rdAck
//     ramWr*, ramRd*, ramRdRst     : RAM write port, read port, read reset
//     ramRdDat                     : registered RAM read data
// -----------------------------------------------------------------------------
interface sdp_ram_arb2_if #(
  parameter int WIDTH     = 32,
  parameter int DEPTH_LOG = 8
);

  logic                 wrReq0;
  logic                 wrReq1;
  logic [DEPTH_LOG-1:0] wrAdr0;
  logic [DEPTH_LOG-1:0] wrAdr1;
  logic [WIDTH-1:0]     wrDat0;
  logic [WIDTH-1:0]     wrDat1;
  logic                 wrAck0;
  logic                 wrAck1;

  logic                 rdReq0;
  logic                 rdReq1;
  logic [DEPTH_LOG-1:0] rdAdr0;
  logic [DEPTH_LOG-1:0] rdAdr1;
  logic                 rdAck0;
  logic                 rdAck1;
  logic                 rdVld0;
  logic                 rdVld1;
  logic [WIDTH-1:0]     rdDat0;
  logic [WIDTH-1:0]     rdDat1;

  logic                 ramWrEn;
  logic [DEPTH_LOG-1:0] ramWrAdr;
  logic [WIDTH-1:0]     ramWrDat;
  logic                 ramRdEn;
  logic [DEPTH_LOG-1:0] ramRdAdr;
  logic                 ramRdRst;
  logic [WIDTH-1:0]     ramRdDat;

  modport slave (
    input  wrReq0, wrReq1, wrAdr0, wrAdr1, wrDat0, wrDat1,
    output wrAck0, wrAck1,
    input  rdReq0, rdReq1, rdAdr0, rdAdr1,
    output rdAck0, rdAck1, rdVld0, rdVld1, rdDat0, rdDat1,
    output ramWrEn, ramWrAdr, ramWrDat, ramRdEn, ramRdAdr, ramRdRst,
    input  ramRdDat
  );

  modport master (
    output wrReq0, wrReq1, wrAdr0, wrAdr1, wrDat0, wrDat1,
    input  wrAck0, wrAck1,
    output rdReq0, rdReq1, rdAdr0, rdAdr1,
    input  rdAck0, rdAck1, rdVld0, rdVld1, rdDat0, rdDat1,
    input  ramWrEn, ramWrAdr, ramWrDat, ramRdEn, ramRdAdr, ramRdRst,
    output ramRdDat
  );

endinterface

// File: rtl/sdp_ram_arb2_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
//   Two-input round-robin arbiter with a one-bit preference pointer.
//   A lone requester always wins; on contention the client named by the
//   pointer wins, and every grant hands preference to the other client.
//   Ports:
//     clk, rst : clock, synchronous active-high reset
//     req      : request per client
//     grant    : one-hot grant, all zero while rst is high
//     gntIdx   : index of the selected client (steers the data muxes)
// -----------------------------------------------------------------------------
module rr_arb2
  import sdp_ram_arb2_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_CLIENTS-1:0] req,
  output logic [N_CLIENTS-1:0] grant,
  output client_t              gntIdx
);

  client_t ptr;
  logic    anyGrant;

  // NOTE: every output gets a value before the case so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    gntIdx = ptr;
    unique case (req)
      2'b01:   gntIdx = 1'b0;
      2'b10:   gntIdx = 1'b1;
      default: gntIdx = ptr;   // contention (or idle, where it is unused)
    endcase
  end

  // Nothing is granted while reset is held.
  assign anyGrant = (|req) && !rst;
  assign grant    = anyGrant ? oneHot(gntIdx) : '0;

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= PTR_RST;
    end else if (anyGrant) begin
      ptr <= ~gntIdx;
    end
  end

endmodule

// File: rtl/sdp_ram_arb2.sv
// -----------------------------------------------------------------------------
// sdp_ram_arb2
//   Arbiter and sequencer placing two clients in front of one simple
//   dual-port RAM (one write port, one registered read port, latency 1).
//   The write port and the read port are shared independently, each by its
//   own round-robin arbiter, so both may be granted in the same cycle.
//   Read data returns to the issuing client one cycle after its rdAck.
//   A read that hits the address being written in the same cycle returns
//   the new word through a one-entry bypass register, because the RAM
//   itself returns the old contents in that case.
//   Ports:
//     clk  : clock, rising edge
//     rst  : synchronous active-high reset
//     bus  : sdp_ram_arb2_if.slave -- client requests/acks/returns and the
//            RAM write port, read port, read reset and read data
// -----------------------------------------------------------------------------
module sdp_ram_arb2
  import sdp_ram_arb2_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 256,
  parameter int DEPTH_LOG = 8
) (
  input  logic          clk,
  input  logic          rst,
  sdp_ram_arb2_if.slave bus
);

  if (DEPTH > (1 << DEPTH_LOG)) begin : gDepthCheck
    $error("sdp_ram_arb2: DEPTH does not fit in DEPTH_LOG address bits");
  end

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic [N_CLIENTS-1:0] wrGrant;
  logic [N_CLIENTS-1:0] rdGrant;
  client_t              wrIdx;
  client_t              rdIdx;

  rr_arb2 uWrArb (
    .clk    (clk),
    .rst    (rst),
    .req    ({bus.wrReq1, bus.wrReq0}),
    .grant  (wrGrant),
    .gntIdx (wrIdx)
  );

  rr_arb2 uRdArb (
    .clk    (clk),
    .rst    (rst),
    .req    ({bus.rdReq1, bus.rdReq0}),
    .grant  (rdGrant),
    .gntIdx (rdIdx)
  );

  // ---------------------------------------------------------------------------
  // RAM write port
  // ---------------------------------------------------------------------------
  logic                 wrEn;
  logic [DEPTH_LOG-1:0] wrAdr;
  logic [WIDTH-1:0]     wrDat;

  assign wrEn  = |wrGrant;
  assign wrAdr = (wrIdx == 1'b1) ? bus.wrAdr1 : bus.wrAdr0;
  assign wrDat = (wrIdx == 1'b1) ? bus.wrDat1 : bus.wrDat0;

  assign bus.wrAck0   = wrGrant[0];
  assign bus.wrAck1   = wrGrant[1];
  assign bus.ramWrEn  = wrEn;
  assign bus.ramWrAdr = wrAdr;
  assign bus.ramWrDat = wrDat;

  // ---------------------------------------------------------------------------
  // RAM read port
  // ---------------------------------------------------------------------------
  logic                 rdEn;
  logic [DEPTH_LOG-1:0] rdAdr;

  assign rdEn  = |rdGrant;
  assign rdAdr = (rdIdx == 1'b1) ? bus.rdAdr1 : bus.rdAdr0;

  assign bus.rdAck0   = rdGrant[0];
  assign bus.rdAck1   = rdGrant[1];
  assign bus.ramRdEn  = rdEn;
  assign bus.ramRdAdr = rdAdr;
  assign bus.ramRdRst = rst;

  // ---------------------------------------------------------------------------
  // Return-tag pipeline and write-to-read bypass
  // ---------------------------------------------------------------------------
  logic             collision;
  logic             retPend;
  client_t          retTag;
  logic             bypFlag;
  logic [WIDTH-1:0] bypWord;

  // The RAM reads old contents when both ports hit one address together.
  assign collision = wrEn && rdEn && (wrAdr == rdAdr);

  always_ff @(posedge clk) begin
    if (rst) begin
      retPend <= 1'b0;
      retTag  <= PTR_RST;
      bypFlag <= 1'b0;
    end else begin
      retPend <= rdEn;
      if (rdEn) begin
        retTag <= rdIdx;
      end
      bypFlag <= collision;
    end
  end

  // NOTE: bypWord is consulted only when bypFlag is set, and bypFlag is
  // reset, so the data register itself carries no reset.
  always_ff @(posedge clk) begin
    if (collision) begin
      bypWord <= wrDat;
    end
  end

  // The return lines are decoded from flops; the RAM data arrives in that
  // same cycle from the RAM's own output register.  Gating with rst keeps a
  // read granted just before reset from surfacing during reset.
  logic             retLive;
  logic [WIDTH-1:0] retWord;
  logic             vld0;
  logic             vld1;

  assign retLive = retPend && !rst;
  assign retWord = bypFlag ? bypWord : bus.ramRdDat;
  assign vld0    = retLive && (retTag == 1'b0);
  assign vld1    = retLive && (retTag == 1'b1);

  assign bus.rdVld0 = vld0;
  assign bus.rdVld1 = vld1;
  assign bus.rdDat0 = vld0 ? retWord : '0;
  assign bus.rdDat1 = vld1 ? retWord : '0;

endmodule

// File: tb/tb_sdp_ram_arb2.sv
// -----------------------------------------------------------------------------
// tb_sdp_ram_arb2
//   Bench for sdp_ram_arb2: a read-first RAM model sits on the RAM ports, a
//   reference model (golden word array, last-winner per port, one pending
//   return) is compared against the DUT every cycle, and directed sequences
//   carry hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_sdp_ram_arb2;

  localparam int WIDTH     = 32;
  localparam int DEPTH     = 256;
  localparam int DEPTH_LOG = 8;

  logic clk;
  logic rst;

  sdp_ram_arb2_if #(.WIDTH(WIDTH), .DEPTH_LOG(DEPTH_LOG)) bus ();

  sdp_ram_arb2 #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DEPTH_LOG(DEPTH_LOG)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nCompared   = 0;
  int nMismatched = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // RAM model: one write port, registered read port returning old contents
  // on a same-address collision.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] ramMem [DEPTH];
  logic [WIDTH-1:0] refMem [DEPTH];

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ramMem[i] = '0;
      refMem[i] = '0;
    end
  end

  always @(posedge clk) begin
    if (bus.ramWrEn) ramMem[bus.ramWrAdr] <= bus.ramWrDat;
    if (bus.ramRdRst)     bus.ramRdDat <= '0;
    else if (bus.ramRdEn) bus.ramRdDat <= ramMem[bus.ramRdAdr];
  end

  // ---------------------------------------------------------------------------
  // Reference model and per-cycle compare
  // ---------------------------------------------------------------------------
  // Winner of one port: a lone requester wins, otherwise whoever lost last.
  function automatic int pick(logic r0, logic r1, int lastWinner);
    if (r0 && r1) return 1 - lastWinner;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  function automatic logic [1:0] vec(int idx);
    if (idx < 0) return 2'b00;
    return (idx == 1) ? 2'b10 : 2'b01;
  endfunction

  bit               expPend = 1'b0;
  int               expCli  = 0;
  logic [WIDTH-1:0] expWord = '0;
  int               lastWr  = 1;
  int               lastRd  = 1;

  always @(negedge clk) begin
    int wWin;
    int rWin;
    logic [DEPTH_LOG-1:0] adr;
    logic [WIDTH-1:0]     dat;
    if (rst) begin
      check("m_rst_acks", 64'({bus.wrAck1, bus.wrAck0, bus.rdAck1, bus.rdAck0}), 64'd0);
      check("m_rst_vld", 64'({bus.rdVld1, bus.rdVld0}), 64'd0);
      check("m_rst_ramrdrst", 64'(bus.ramRdRst), 64'd1);
      expPend = 1'b0;
      lastWr  = 1;
      lastRd  = 1;
    end else begin
      // Return of the read granted in the previous cycle.
      check("m_rdvld", 64'({bus.rdVld1, bus.rdVld0}), 64'(expPend ? vec(expCli) : 2'b00));
      if (expPend)
        check("m_rddat", 64'((expCli == 1) ? bus.rdDat1 : bus.rdDat0), 64'(expWord));
      check("m_ramrdrst", 64'(bus.ramRdRst), 64'd0);

      // Write port: the write lands in the golden array before the read
      // below looks it up, so a same-cycle read sees the new word.
      wWin = pick(bus.wrReq0, bus.wrReq1, lastWr);
      check("m_wrack", 64'({bus.wrAck1, bus.wrAck0}), 64'(vec(wWin)));
      check("m_ramwren", 64'(bus.ramWrEn), 64'(wWin >= 0));
      if (wWin >= 0) begin
        adr = (wWin == 1) ? bus.wrAdr1 : bus.wrAdr0;
        dat = (wWin == 1) ? bus.wrDat1 : bus.wrDat0;
        check("m_ramwradr", 64'(bus.ramWrAdr), 64'(adr));
        check("m_ramwrdat", 64'(bus.ramWrDat), 64'(dat));
        refMem[adr] = dat;
        lastWr      = wWin;
      end

      rWin = pick(bus.rdReq0, bus.rdReq1, lastRd);
      check("m_rdack", 64'({bus.rdAck1, bus.rdAck0}), 64'(vec(rWin)));
      check("m_ramrden", 64'(bus.ramRdEn), 64'(rWin >= 0));
      expPend = (rWin >= 0);
      if (rWin >= 0) begin
        adr = (rWin == 1) ? bus.rdAdr1 : bus.rdAdr0;
        check("m_ramrdadr", 64'(bus.ramRdAdr), 64'(adr));
        expWord = refMem[adr];
        expCli  = rWin;
        lastRd  = rWin;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus with literal expectations
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idleReqs();
    bus.wrReq0 = 1'b0;
    bus.wrReq1 = 1'b0;
    bus.rdReq0 = 1'b0;
    bus.rdReq1 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wrCnt0, wrCnt1, rdCnt0, rdCnt1;

    // Reset held 3 cycles with every request asserted.
    rst        = 1'b1;
    bus.wrReq0 = 1'b1; bus.wrAdr0 = 8'h30; bus.wrDat0 = 32'h3030_3030;
    bus.wrReq1 = 1'b1; bus.wrAdr1 = 8'h31; bus.wrDat1 = 32'h3131_3131;
    bus.rdReq0 = 1'b1; bus.rdAdr0 = 8'h30;
    bus.rdReq1 = 1'b1; bus.rdAdr1 = 8'h31;
    repeat (3) begin
      sample();
      check("rst_acks", 64'({bus.wrAck1, bus.wrAck0, bus.rdAck1, bus.rdAck0}), 64'd0);
      check("rst_vld", 64'({bus.rdVld1, bus.rdVld0}), 64'd0);
      check("rst_dat0", 64'(bus.rdDat0), 64'd0);
      check("rst_dat1", 64'(bus.rdDat1), 64'd0);
    end
    tick();
    rst = 1'b0;
    sample();
    check("post_rst_wrack", 64'({bus.wrAck1, bus.wrAck0}), 64'h1);
    check("post_rst_rdack", 64'({bus.rdAck1, bus.rdAck0}), 64'h1);
    tick();
    idleReqs();

    // Solo write by client 1, then a read of the same word two cycles later.
    tick();
    bus.wrReq1 = 1'b1; bus.wrAdr1 = 8'h10; bus.wrDat1 = 32'hA5A5_A5A5;
    sample();
    check("solo_wrack", 64'({bus.wrAck1, bus.wrAck0}), 64'h2);
    tick();
    bus.wrReq1 = 1'b0;
    tick();
    bus.rdReq1 = 1'b1; bus.rdAdr1 = 8'h10;
    sample();
    check("solo_rdack", 64'({bus.rdAck1, bus.rdAck0}), 64'h2);
    tick();
    bus.rdReq1 = 1'b0;
    sample();
    check("solo_rdvld", 64'({bus.rdVld1, bus.rdVld0}), 64'h2);
    check("solo_rddat1", 64'(bus.rdDat1), 64'hA5A5_A5A5);

    // Contention on both ports for 6 cycles.
    wrCnt0 = 0; wrCnt1 = 0; rdCnt0 = 0; rdCnt1 = 0;
    tick();
    bus.wrReq0 = 1'b1; bus.wrAdr0 = 8'h40; bus.wrDat0 = 32'h4000_0000;
    bus.wrReq1 = 1'b1; bus.wrAdr1 = 8'h50; bus.wrDat1 = 32'h5000_0000;
    bus.rdReq0 = 1'b1; bus.rdAdr0 = 8'h10;
    bus.rdReq1 = 1'b1; bus.rdAdr1 = 8'h10;
    for (int i = 0; i < 6; i++) begin
      sample();
      check("cont_wrack", 64'({bus.wrAck1, bus.wrAck0}), (i % 2 == 1) ? 64'h2 : 64'h1);
      check("cont_rdack", 64'({bus.rdAck1, bus.rdAck0}), (i % 2 == 1) ? 64'h2 : 64'h1);
      wrCnt0 += int'(bus.wrAck0); wrCnt1 += int'(bus.wrAck1);
      rdCnt0 += int'(bus.rdAck0); rdCnt1 += int'(bus.rdAck1);
      if (i < 5) tick();
    end
    tick();
    idleReqs();
    check("cont_wrcnt0", 64'(wrCnt0), 64'd3);
    check("cont_wrcnt1", 64'(wrCnt1), 64'd3);
    check("cont_rdcnt0", 64'(rdCnt0), 64'd3);
    check("cont_rdcnt1", 64'(rdCnt1), 64'd3);

    // Collision: old word 0x11111111, new word written while it is read.
    tick();
    bus.wrReq0 = 1'b1; bus.wrAdr0 = 8'h20; bus.wrDat0 = 32'h1111_1111;
    sample();
    check("coll_pre_wrack", 64'(bus.wrAck0), 64'd1);
    tick();
    idleReqs();
    tick();
    bus.wrReq0 = 1'b1; bus.wrAdr0 = 8'h20; bus.wrDat0 = 32'h2222_2222;
    bus.rdReq1 = 1'b1; bus.rdAdr1 = 8'h20;
    sample();
    check("coll_acks", 64'({bus.wrAck0, bus.rdAck1}), 64'h3);
    tick();
    idleReqs();
    sample();
    check("coll_rdvld1", 64'(bus.rdVld1), 64'd1);
    check("coll_rddat1", 64'(bus.rdDat1), 64'h2222_2222);
    tick();
    bus.rdReq1 = 1'b1; bus.rdAdr1 = 8'h20;
    tick();
    idleReqs();
    sample();
    check("coll_reread", 64'(bus.rdDat1), 64'h2222_2222);

    // Streaming: fill 0..7, then read them back-to-back.
    for (int i = 0; i < 8; i++) begin
      tick();
      bus.wrReq1 = 1'b1; bus.wrAdr1 = DEPTH_LOG'(i); bus.wrDat1 = 32'h100 + 32'(i);
      sample();
      check("fill_wrack1", 64'(bus.wrAck1), 64'd1);
    end
    tick();
    idleReqs();
    for (int i = 0; i <= 8; i++) begin
      tick();
      if (i < 8) begin
        bus.rdReq0 = 1'b1; bus.rdAdr0 = DEPTH_LOG'(i);
      end else begin
        bus.rdReq0 = 1'b0;
      end
      sample();
      if (i > 0) begin
        check("stream_vld0", 64'({bus.rdVld1, bus.rdVld0}), 64'h1);
        check("stream_dat0", 64'(bus.rdDat0), 64'h100 + 64'(i - 1));
      end
    end

    // Reset right after a read grant: the return never appears, and the
    // read pointer goes back to client 0 (client 1 would win otherwise).
    tick();
    bus.rdReq0 = 1'b1; bus.rdAdr0 = 8'h03;
    sample();
    check("midrst_rdack0", 64'(bus.rdAck0), 64'd1);
    tick();
    bus.rdReq0 = 1'b0;
    rst = 1'b1;
    sample();
    check("midrst_novld", 64'({bus.rdVld1, bus.rdVld0}), 64'd0);
    tick();
    rst = 1'b0;
    bus.rdReq0 = 1'b1; bus.rdAdr0 = 8'h05;
    bus.rdReq1 = 1'b1; bus.rdAdr1 = 8'h06;
    sample();
    check("midrst_ptr0", 64'({bus.rdAck1, bus.rdAck0}), 64'h1);
    tick();
    idleReqs();
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/sdp_ram_arb2.md
Name: sdp_ram_arb2

Overview:
- Two-client arbiter and sequencer in front of one simple dual-port RAM (1 write port, 1 registered read port, read latency 1).
- Shares the write port and the read port independently between client 0 and client 1, using round-robin per port.
- Returns read data to the issuing client with a valid pulse.
- Forwards same-cycle write data so a colliding read returns the new word.

Parameters:
- WIDTH, 32, data word width.
- DEPTH, 256, RAM word count.
- DEPTH_LOG, 8, address width (clog2 of DEPTH).

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- wrReq0/wrReq1  in  1  write request, held until acked.
- wrAdr0/wrAdr1  in  DEPTH_LOG  write address.
- wrDat0/wrDat1  in  WIDTH  write data.
- wrAck0/wrAck1  out  1  write grant pulse; combinational, same cycle as the RAM write.
- rdReq0/rdReq1  in  1  read request, held until acked.
- rdAdr0/rdAdr1  in  DEPTH_LOG  read address.
- rdAck0/rdAck1  out  1  read grant pulse; combinational.
- rdVld0/rdVld1  out  1  read data valid, registered, 1 cycle after rdAck.
- rdDat0/rdDat1  out  WIDTH  read return data; valid only with rdVld.
- ramWrEn  out  1  RAM write enable.
- ramWrAdr  out  DEPTH_LOG  RAM write address.
- ramWrDat  out  WIDTH  RAM write data.
- ramRdEn  out  1  RAM read enable.
- ramRdAdr  out  DEPTH_LOG  RAM read address.
- ramRdRst  out  1  RAM read-register reset; equals rst.
- ramRdDat  in  WIDTH  RAM read data, registered inside the RAM.

Behaviour:
- Reset, applied by clk edge with rst=1:
  - wrPtr=0 and rdPtr=0 (preferred client = 0).
  - rdVld0/1=0, rdDat0/1=0.
  - Bypass flag cleared; return tag cleared.
  - All acks are 0 while rst=1, so no RAM writes or reads are issued.
- Write arbitration, combinational each cycle:
  - Only one client requesting: that client is granted.
  - Both requesting: the client equal to wrPtr is granted.
  - Grant drives ramWrEn=1, ramWrAdr/ramWrDat = muxed client fields, and wrAckN=1.
  - On a grant to client k, wrPtr <= ~k at the clock edge; wrPtr is unchanged with no grant.
- Read arbitration: identical structure using rdPtr; drives ramRdEn, ramRdAdr, rdAckN.
- Read return:
  - On a read grant to client k, register tag=k, pending=1.
  - Next cycle: rdVldk=1 for exactly 1 cycle; rdDatk = ramRdDat, or the bypass word if the bypass flag is set. The other client's rdVld stays 0.
  - Back-to-back grants produce back-to-back rdVld pulses, throughput 1 read/cycle.
- Collision (RAW bypass):
  - Condition: ramWrEn && ramRdEn && ramWrAdr==ramRdAdr in the same cycle.
  - Register the bypass flag=1 and the bypass word=ramWrDat.
  - The return in the following cycle uses the bypass word, so the read returns the new data, not the stale RAM content.
  - Flag cleared the following cycle unless the collision repeats.
- Request rules:
  - Address and data must be stable while a request is held.
  - Deasserting a request before its ack is permitted; the request is simply withdrawn.
- Reset mid-operation: a read granted in the cycle before rst rises produces no rdVld; pending and flags are cleared.
- Independence: write and read arbitration never block each other; both ports may be granted in the same cycle, to the same or different clients.
- No address range checking; addresses are taken modulo DEPTH by width.

Decomposition:
- Shared package: client-index type (1 bit), N_CLIENTS=2 constant, and the pointer reset value.
- Sub-module: rr_arb2 (req[1:0], ptr register, grant[1:0], gntIdx), instantiated twice, once for the write port and once for the read port.
- The top level holds the address/data muxes, the return-tag pipeline and the bypass register.

Test Plan:
- Reset: hold rst 3 cycles with all requests high -> all acks 0, rdVld 0, rdDat 0; after release, client 0 is granted first on both ports.
- Solo write then read: client 1 writes 0xA5A5A5A5 to address 0x10; two cycles later it reads 0x10 -> rdAck1 pulses, next cycle rdVld1=1 with rdDat1=0xA5A5A5A5 and rdVld0=0.
- Contention: both clients hold wrReq for 6 cycles -> grants alternate 0,1,0,1,0,1 and each client writes exactly 3 words; same pattern on reads.
- Collision bypass: address 0x20 holds 0x11111111; in one cycle client 0 writes 0x22222222 to 0x20 while client 1 reads 0x20 -> next cycle rdVld1=1 with rdDat1=0x22222222.
- Streaming: client 0 reads addresses 0..7 back-to-back -> 8 consecutive rdVld0 pulses returning the data in address order.
- Mid-op reset: rdAck0 in cycle N, rst=1 in cycle N+1 -> rdVld0 stays 0; after reset, rdPtr=0.
